// File: rtl/pred_rf_rot.sv
// Predicate register file for a CGRA PE with rotating base, per-entry valid bits,
// write-back-over-channel priority and a sticky error flag. State updates on the falling clock edge.
module pred_rf_rot #(
  parameter int PW    = 4,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int NCH   = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*PW-1:0] ch_p_in,
  input  logic [NCH-1:0]    wr_ch_sel,
  input  logic [AW-1:0]     wr_ch_addr,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [PW-1:0]     wb_data,
  input  logic [NCH-1:0]    fu_src_sel,
  input  logic [AW-1:0]     fu_rd_addr,
  output logic [PW-1:0]     pred_out,
  output logic              pred_out_vld,
  input  logic [AW-1:0]     snd_addr,
  input  logic [NCH-1:0]    snd_en,
  output logic [NCH*PW-1:0] ch_p_out,
  input  logic              iter_adv,
  output logic [AW-1:0]     rrb,
  output logic              wr_conflict,
  output logic              err
);

  logic [PW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_rrb;
  logic             r_conflict;
  logic             r_err;

  logic [AW-1:0] w_wr_phys, w_wb_phys, w_rd_phys, w_snd_phys;
  logic          w_wr_zero, w_wr_one, w_fu_zero, w_fu_one;
  logic          w_ch_we, w_err_set;
  logic [PW-1:0] w_ch_data, w_fu_ch_data;

  // Logical-to-physical mapping relies on AW-bit wrap-around.
  assign w_wr_phys  = wr_ch_addr + r_rrb;
  assign w_wb_phys  = wb_addr + r_rrb;
  assign w_rd_phys  = fu_rd_addr + r_rrb;
  assign w_snd_phys = snd_addr + r_rrb;

  assign w_wr_zero = (wr_ch_sel == '0);
  assign w_wr_one  = !w_wr_zero && ((wr_ch_sel & (wr_ch_sel - NCH'(1))) == '0);
  assign w_fu_zero = (fu_src_sel == '0);
  assign w_fu_one  = !w_fu_zero && ((fu_src_sel & (fu_src_sel - NCH'(1))) == '0);
  assign w_ch_we   = w_wr_one;

  assign w_err_set = (!w_wr_zero && !w_wr_one) || (!w_fu_zero && !w_fu_one) ||
                     ((snd_en != '0) && !r_vld[w_snd_phys]);

  always_comb begin
    w_ch_data    = '0;
    w_fu_ch_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (wr_ch_sel[k])  w_ch_data    = ch_p_in[k*PW +: PW];
      if (fu_src_sel[k]) w_fu_ch_data = ch_p_in[k*PW +: PW];
    end
  end

  // Write-back is issued after the channel write so it wins on a shared entry.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_vld      <= '0;
      r_rrb      <= '0;
      r_conflict <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_ch_we) begin
        r_mem[w_wr_phys] <= w_ch_data;
        r_vld[w_wr_phys] <= 1'b1;
      end
      if (wb_en) begin
        r_mem[w_wb_phys] <= wb_data;
        r_vld[w_wb_phys] <= 1'b1;
      end
      if (iter_adv) r_rrb <= r_rrb - AW'(1);
      r_conflict <= w_ch_we && wb_en && (w_wr_phys == w_wb_phys);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    pred_out     = '0;
    pred_out_vld = 1'b0;
    if (!RST) begin
      if (w_fu_zero) begin
        pred_out_vld = r_vld[w_rd_phys];
        pred_out     = r_vld[w_rd_phys] ? r_mem[w_rd_phys] : '0;
      end else if (w_fu_one) begin
        pred_out_vld = 1'b1;
        pred_out     = w_fu_ch_data;
      end
    end
  end

  always_comb begin
    ch_p_out = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!RST && snd_en[k] && r_vld[w_snd_phys]) ch_p_out[k*PW +: PW] = r_mem[w_snd_phys];
    end
  end

  assign rrb         = r_rrb;
  assign wr_conflict = r_conflict;
  assign err         = r_err;

endmodule

// File: tb/tb_pred_rf_rot.sv
// Bench for pred_rf_rot: directed scenarios followed by random traffic,
// every step compared against an array-based reference model.
module tb_pred_rf_rot;

  logic        CLK;
  logic        RST;
  logic [11:0] ch_p_in;
  logic [2:0]  wr_ch_sel;
  logic [5:0]  wr_ch_addr;
  logic        wb_en;
  logic [5:0]  wb_addr;
  logic [3:0]  wb_data;
  logic [2:0]  fu_src_sel;
  logic [5:0]  fu_rd_addr;
  logic [3:0]  pred_out;
  logic        pred_out_vld;
  logic [5:0]  snd_addr;
  logic [2:0]  snd_en;
  logic [11:0] ch_p_out;
  logic        iter_adv;
  logic [5:0]  rrb;
  logic        wr_conflict;
  logic        err;

  pred_rf_rot dut (
    .CLK(CLK), .RST(RST), .ch_p_in(ch_p_in), .wr_ch_sel(wr_ch_sel),
    .wr_ch_addr(wr_ch_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fu_src_sel(fu_src_sel), .fu_rd_addr(fu_rd_addr), .pred_out(pred_out),
    .pred_out_vld(pred_out_vld), .snd_addr(snd_addr), .snd_en(snd_en),
    .ch_p_out(ch_p_out), .iter_adv(iter_adv), .rrb(rrb),
    .wr_conflict(wr_conflict), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model state
  logic [3:0] m_mem [64];
  bit         m_vld [64];
  int         m_rrb;
  bit         m_err;
  bit         m_conf;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int phys(input logic [5:0] a);
    return (int'(a) + m_rrb) % 64;
  endfunction

  function automatic logic [3:0] chan(input int k);
    logic [11:0] v;
    v = ch_p_in;
    return v[k*4 +: 4];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = 4'h0;
      m_vld[i] = 1'b0;
    end
    m_rrb  = 0;
    m_err  = 1'b0;
    m_conf = 1'b0;
  endtask

  task automatic model_edge();
    int  pw, pb, ps, wn, fn;
    bit  ch_ok;
    if (RST) begin
      model_reset();
      return;
    end
    pw = phys(wr_ch_addr);
    pb = phys(wb_addr);
    ps = phys(snd_addr);
    wn = $countones(wr_ch_sel);
    fn = $countones(fu_src_sel);
    ch_ok = (wn == 1);
    if (wn > 1 || fn > 1 || (snd_en != 3'b000 && !m_vld[ps])) m_err = 1'b1;
    m_conf = ch_ok && wb_en && (pw == pb);
    if (ch_ok) begin
      for (int k = 0; k < 3; k++) if (wr_ch_sel[k]) m_mem[pw] = chan(k);
      m_vld[pw] = 1'b1;
    end
    if (wb_en) begin
      m_mem[pb] = wb_data;
      m_vld[pb] = 1'b1;
    end
    if (iter_adv) m_rrb = (m_rrb == 0) ? 63 : m_rrb - 1;
  endtask

  task automatic check_all();
    logic [3:0]  ep;
    logic        ev;
    logic [11:0] eo;
    int          rp, sp;
    ep = 4'h0; ev = 1'b0; eo = 12'h0;
    rp = phys(fu_rd_addr);
    sp = phys(snd_addr);
    if (!RST) begin
      if ($countones(fu_src_sel) == 0) begin
        ev = m_vld[rp];
        ep = ev ? m_mem[rp] : 4'h0;
      end else if ($countones(fu_src_sel) == 1) begin
        ev = 1'b1;
        for (int k = 0; k < 3; k++) if (fu_src_sel[k]) ep = chan(k);
      end
      for (int k = 0; k < 3; k++)
        if (snd_en[k] && m_vld[sp]) eo[k*4 +: 4] = m_mem[sp];
    end
    chk("pred_out", 32'(pred_out), 32'(ep));
    chk("pred_out_vld", 32'(pred_out_vld), 32'(ev));
    chk("ch_p_out", 32'(ch_p_out), 32'(eo));
    chk("rrb", 32'(rrb), 32'(m_rrb));
    chk("err", 32'(err), 32'(m_err));
    chk("wr_conflict", 32'(wr_conflict), 32'(m_conf));
  endtask

  // inputs are set just after a falling edge; check, then let the next falling edge commit
  task automatic step();
    #1;
    check_all();
    @(negedge CLK);
    model_edge();
    #1;
  endtask

  task automatic clr_in();
    ch_p_in = 12'h0; wr_ch_sel = 3'b000; wr_ch_addr = 6'd0;
    wb_en = 1'b0; wb_addr = 6'd0; wb_data = 4'h0;
    fu_src_sel = 3'b000; fu_rd_addr = 6'd0;
    snd_addr = 6'd0; snd_en = 3'b000; iter_adv = 1'b0;
  endtask

  function automatic logic [2:0] rand_sel();
    int r;
    r = $urandom_range(0, 15);
    if (r < 4)  return 3'b000;
    if (r < 13) return 3'(1 << (r % 3));
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    clr_in();
    RST = 1'b1;
    model_reset();
    #3;
    check_all();
    RST = 1'b0;

    // channel write through ch1, then read via FU and send path
    clr_in();
    wr_ch_sel = 3'b010; ch_p_in = 12'h0A0; wr_ch_addr = 6'd7;
    step();
    clr_in();
    fu_rd_addr = 6'd7; snd_en = 3'b101; snd_addr = 6'd7;
    #1;
    chk("chw_pred", 32'(pred_out), 32'h A);
    chk("chw_vld", 32'(pred_out_vld), 32'h1);
    chk("chw_send", 32'(ch_p_out), 32'h A0A);
    step();

    // channel and write-back collide on address 9
    clr_in();
    wr_ch_sel = 3'b001; ch_p_in = 12'h003; wr_ch_addr = 6'd9;
    wb_en = 1'b1; wb_addr = 6'd9; wb_data = 4'hC;
    step();
    clr_in();
    fu_rd_addr = 6'd9;
    #1;
    chk("conf_data", 32'(pred_out), 32'h C);
    chk("conf_pulse", 32'(wr_conflict), 32'h1);
    step();
    clr_in();
    #1;
    chk("conf_clear", 32'(wr_conflict), 32'h0);
    step();

    // reset mid-operation, with a write pending on the reset edge
    clr_in();
    wb_en = 1'b1; wb_addr = 6'd5; wb_data = 4'h7; fu_rd_addr = 6'd7;
    RST = 1'b1;
    model_reset();
    step();
    RST = 1'b0;
    clr_in();
    fu_rd_addr = 6'd5;
    #1;
    chk("rst_vld5", 32'(pred_out_vld), 32'h0);
    chk("rst_pred", 32'(pred_out), 32'h0);
    chk("rst_rrb", 32'(rrb), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    step();

    // rotation
    clr_in();
    wb_en = 1'b1; wb_addr = 6'd0; wb_data = 4'h5;
    step();
    clr_in();
    iter_adv = 1'b1;
    step();
    clr_in();
    fu_rd_addr = 6'd1;
    #1;
    chk("rot_rrb", 32'(rrb), 32'd63);
    chk("rot_l1", 32'(pred_out), 32'h5);
    step();
    clr_in();
    fu_rd_addr = 6'd0;
    #1;
    chk("rot_l0_vld", 32'(pred_out_vld), 32'h0);
    step();

    // wrap: logical 1 at rrb=63 is physical 0, then a full rotation
    clr_in();
    wb_en = 1'b1; wb_addr = 6'd1; wb_data = 4'h9;
    step();
    clr_in();
    iter_adv = 1'b1;
    for (int i = 0; i < 64; i++) step();
    clr_in();
    fu_rd_addr = 6'd1;
    #1;
    chk("wrap_rrb", 32'(rrb), 32'd63);
    chk("wrap_data", 32'(pred_out), 32'h9);
    step();

    // illegal selects
    clr_in();
    wr_ch_sel = 3'b011; ch_p_in = 12'hFFF; wr_ch_addr = 6'd20;
    step();
    clr_in();
    fu_rd_addr = 6'd20;
    #1;
    chk("err_set", 32'(err), 32'h1);
    chk("err_nowrite", 32'(pred_out_vld), 32'h0);
    step();
    step();
    clr_in();
    fu_src_sel = 3'b110; ch_p_in = 12'h5A3;
    #1;
    chk("fu_ill_pred", 32'(pred_out), 32'h0);
    chk("fu_ill_vld", 32'(pred_out_vld), 32'h0);
    chk("err_sticky", 32'(err), 32'h1);
    step();
    clr_in();
    RST = 1'b1;
    model_reset();
    step();
    RST = 1'b0;
    clr_in();
    #1;
    chk("err_cleared", 32'(err), 32'h0);
    step();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      clr_in();
      if ($urandom_range(0, 59) == 0) begin
        RST = 1'b1;
        model_reset();
        step();
        RST = 1'b0;
      end else begin
        ch_p_in    = 12'($urandom);
        wr_ch_sel  = rand_sel();
        fu_src_sel = rand_sel();
        wr_ch_addr = 6'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 63));
        wb_addr    = 6'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 63));
        fu_rd_addr = 6'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 63));
        snd_addr   = 6'($urandom_range(0, 7));
        wb_en      = 1'($urandom_range(0, 1));
        wb_data    = 4'($urandom);
        snd_en     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        iter_adv   = ($urandom_range(0, 3) == 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pred_rf_rot.md
Name: pred_rf_rot

Overview:
Parametrised predicate register file for a CGRA PE, successor to the fixed 4-bit/64-entry/3-channel predicate file. Predicates arrive from NCH neighbour/bus channels and from FU write-back, and are routed to the FU and back out to the channels. New over the previous generation:
- reset
- per-entry valid bits
- rotating register base for modulo-scheduled loops
- defined write-conflict priority
- sticky error reporting

Parameters:
PW, 4, predicate width in bits
DEPTH, 64, entries; power of two
AW, 6, log2(DEPTH)
NCH, 3, channel count; channel 0 = edge A, channel 1 = edge B, channel NCH-1 = bus

Ports:
CLK  in  1  clock; all state updates on falling edge
RST  in  1  asynchronous, active-high reset
ch_p_in  in  NCH*PW  channel predicate inputs; channel k occupies bits [k*PW +: PW]
wr_ch_sel  in  NCH  one-hot channel-to-file write select; 0 = no channel write
wr_ch_addr  in  AW  logical address for channel write
wb_en  in  1  FU write-back enable
wb_addr  in  AW  logical write-back address
wb_data  in  PW  FU write-back predicate
fu_src_sel  in  NCH  one-hot FU source; 0 = register file
fu_rd_addr  in  AW  logical FU read address
pred_out  out  PW  predicate to FU
pred_out_vld  out  1  pred_out is valid
snd_addr  in  AW  logical send address
snd_en  in  NCH  per-channel output enable (multi-hot allowed)
ch_p_out  out  NCH*PW  channel predicate outputs
iter_adv  in  1  advance the rotating base by one iteration
rrb  out  AW  current rotating register base
wr_conflict  out  1  registered 1-cycle pulse: channel write and write-back hit the same physical entry
err  out  1  sticky error flag; cleared only by RST

Behaviour:
- Address mapping: phys = (logical + rrb) mod DEPTH, using AW-bit wrap-around arithmetic. Applies to every address port.
- Reset (asynchronous, RST=1):
  - all entries = 0; all valid bits = 0
  - rrb = 0, wr_conflict = 0, err = 0
  - pred_out and ch_p_out read as 0, pred_out_vld = 0
  - Reset mid-loop discards all state; no write completes on an edge where RST=1.
- Writes, on negedge CLK:
  - Channel write: when wr_ch_sel is one-hot, entry[phys(wr_ch_addr)] <= selected channel data; valid <= 1.
  - FU write-back: when wb_en=1, entry[phys(wb_addr)] <= wb_data; valid <= 1.
  - Both to the same physical entry: write-back wins; wr_conflict = 1 for that cycle.
  - Both to different entries: both complete.
- Rotation: iter_adv=1 at negedge sets rrb <= rrb - 1 (DEPTH-1 wraps to... 0 wraps to DEPTH-1). Writes on that same edge use the old rrb.
- Reads (combinational from the array and the current rrb):
  - Write-to-read latency is one edge; there is no same-edge bypass, so a read concurrent with a write returns the old value.
- FU path:
  - fu_src_sel one-hot: pred_out = that channel's input; pred_out_vld = 1.
  - fu_src_sel = 0: pred_out = entry[phys(fu_rd_addr)]; pred_out_vld = that entry's valid bit. An invalid entry drives pred_out = 0.
- Send path: ch_p_out[k] = entry[phys(snd_addr)] when snd_en[k]=1 and the entry is valid; otherwise 0.
- Errors: err sets at negedge on any of:
  - wr_ch_sel not one-hot and not zero
  - fu_src_sel not one-hot and not zero
  - snd_en nonzero toward an invalid entry
  When wr_ch_sel is illegal, no channel write occurs. When fu_src_sel is illegal, pred_out = 0 and pred_out_vld = 0.

Test Plan:
- Reset: RST pulse mid-operation after writes -> pred_out=0, pred_out_vld=0, rrb=0, err=0; read of address 5 shows vld=0.
- Channel write: wr_ch_sel=3'b010, ch_p_in ch1=4'hA, wr_ch_addr=7; next cycle fu_rd_addr=7 -> pred_out=4'hA, pred_out_vld=1; snd_en=3'b101, snd_addr=7 -> ch0 out=4'hA, ch1 out=0, ch2 out=4'hA.
- Conflict: same edge, channel write 4'h3 and wb_en write 4'hC, both to address 9 -> entry 9 = 4'hC; wr_conflict=1 for exactly one cycle.
- Rotation: write 4'h5 at logical 0 with rrb=0; pulse iter_adv -> rrb=63; logical 1 reads 4'h5, logical 0 reads invalid.
- Wrap: with rrb=63, write logical 1 -> physical 0; 64 iter_adv pulses return rrb to 63 with data intact.
- Errors: wr_ch_sel=3'b011 -> no write, err=1 and stays 1 until RST; fu_src_sel=3'b110 -> pred_out=0, pred_out_vld=0.
